// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: FSM state encoding,
// word width and the width of the word counter.
package prefetch_queue_pkg;

    localparam int PQ_MAX_DEPTH = 8;
    localparam int WORD_W       = 16;
    localparam int PQ_CNT_W     = 4;   // holds 0..PQ_MAX_DEPTH

    typedef enum logic [1:0] {
        PQ_IDLE    = 2'd0,   // no bus request
        PQ_REQ     = 2'd1,   // read_req held until read_ack
        PQ_DISCARD = 2'd2    // stale request in flight, its data is dropped
    } pq_state_e;

endpackage

// File: rtl/prefetch_shift_buffer.sv
// Slot array for the prefetch queue: each cycle the words shift left by the
// consumed amount, then an optional new word lands in the first free slot.
// Slots above the word count are always zero.
module prefetch_shift_buffer
    import prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    input  logic                      clear_i,
    input  logic [1:0]                consume_i,
    input  logic                      append_i,
    input  logic [WORD_W-1:0]         data_i,
    output logic [DEPTH*WORD_W-1:0]   slots_o,
    output logic [PQ_CNT_W-1:0]       count_o
);

    logic [WORD_W-1:0]   slot_q [DEPTH];
    logic [WORD_W-1:0]   slot_d [DEPTH];
    logic [PQ_CNT_W-1:0] count_q;
    logic [PQ_CNT_W-1:0] count_d;
    logic [PQ_CNT_W-1:0] wr_idx;

    // Next slot contents: shift by consume first, then append at the new tail.
    always_comb begin
        wr_idx  = count_q - {2'b00, consume_i};
        count_d = clear_i ? '0 : wr_idx + {{(PQ_CNT_W-1){1'b0}}, append_i};
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = '0;
            if (!clear_i) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == i + int'(consume_i)) begin
                        slot_d[i] = slot_q[j];
                    end
                end
                if (append_i && (i == int'(wr_idx))) begin
                    slot_d[i] = data_i;
                end
            end
        end
    end

    // Slot and count registers, cleared by the asynchronous reset.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // Flatten the slot array, word 0 in the low bits.
    always_comb begin
        slots_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slots_o[i*WORD_W +: WORD_W] = slot_q[i];
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction-word prefetch queue. Fetches 16-bit words ahead of execution,
// one bus request outstanding at most, and presents IR plus extension words
// to the sequencer and decoder. Bus and odd-address errors are sticky until
// the next flush.
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic [1:0]  consume,
    output logic        read_req,
    output logic [31:0] read_addr,
    input  logic        read_ack,
    input  logic        read_err,
    input  logic [15:0] read_data,
    output logic [15:0] ir,
    output logic [47:0] prefetch_ir,
    output logic [31:0] prefetch_pc,
    output logic        prefetch_ir_valid,
    output logic        prefetch_ir_valid_32,
    output logic        prefetch_ir_valid_48,
    output logic        prefetch_bus_error,
    output logic        prefetch_addr_error
);

    if (DEPTH < 3 || DEPTH > PQ_MAX_DEPTH) begin : g_bad_depth
        $error("prefetch_queue: DEPTH must be in 3..8");
    end

    localparam logic [PQ_CNT_W-1:0] DEPTH_C = PQ_CNT_W'(DEPTH);

    pq_state_e              state_q;
    logic                   read_req_q;
    logic [31:0]            read_addr_q;
    logic [31:0]            pc_q;
    logic                   bus_err_q;
    logic                   addr_err_q;
    logic                   enable_q;

    logic [PQ_CNT_W-1:0]    count;
    logic [DEPTH*WORD_W-1:0] slots;
    logic [1:0]             consume_eff;
    logic [PQ_CNT_W-1:0]    count_after;
    logic [PQ_CNT_W-1:0]    count_next;
    logic                   ack_ok;
    logic                   space_now;
    logic                   space_next;

    // Clamp consume to the word count so an illegal request cannot underflow.
    always_comb begin
        consume_eff = ({2'b00, consume} > count) ? count[1:0] : consume;
        count_after = count - {2'b00, consume_eff};
        ack_ok      = (state_q == PQ_REQ) && read_ack && !read_err && !flush;
        count_next  = count_after + {{(PQ_CNT_W-1){1'b0}}, ack_ok};
        space_now   = count_after < DEPTH_C;
        space_next  = count_next < DEPTH_C;
    end

    prefetch_shift_buffer #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .clear_i   (flush),
        .consume_i (consume_eff),
        .append_i  (ack_ok),
        .data_i    (read_data),
        .slots_o   (slots),
        .count_o   (count)
    );

    // Fetch FSM with registered bus request, address, pc and error flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PQ_IDLE;
            read_req_q  <= 1'b0;
            read_addr_q <= '0;
            pc_q        <= '0;
            bus_err_q   <= 1'b0;
            addr_err_q  <= 1'b0;
            enable_q    <= 1'b0;
        end else if (flush) begin
            pc_q        <= new_pc;
            read_addr_q <= new_pc;
            bus_err_q   <= 1'b0;
            addr_err_q  <= new_pc[0];
            enable_q    <= 1'b1;
            if (state_q != PQ_IDLE && !read_ack) begin
                // The old cycle must still complete on the bus; drop its data.
                state_q    <= PQ_DISCARD;
                read_req_q <= 1'b1;
            end else if (new_pc[0]) begin
                state_q    <= PQ_IDLE;
                read_req_q <= 1'b0;
            end else begin
                state_q    <= PQ_REQ;
                read_req_q <= 1'b1;
            end
        end else begin
            pc_q <= pc_q + {29'b0, consume_eff, 1'b0};
            case (state_q)
                PQ_IDLE: begin
                    if (enable_q && !bus_err_q && !addr_err_q && space_now) begin
                        state_q    <= PQ_REQ;
                        read_req_q <= 1'b1;
                    end
                end
                PQ_REQ: begin
                    if (read_ack) begin
                        if (read_err) begin
                            bus_err_q  <= 1'b1;
                            state_q    <= PQ_IDLE;
                            read_req_q <= 1'b0;
                        end else begin
                            read_addr_q <= read_addr_q + 32'd2;
                            if (!space_next) begin
                                state_q    <= PQ_IDLE;
                                read_req_q <= 1'b0;
                            end
                        end
                    end
                end
                PQ_DISCARD: begin
                    if (read_ack) begin
                        if (addr_err_q) begin
                            state_q    <= PQ_IDLE;
                            read_req_q <= 1'b0;
                        end else begin
                            state_q    <= PQ_REQ;
                            read_req_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= PQ_IDLE;
                    read_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Retiring more words than are queued is a sequencer bug.
    a_consume_le_count: assert property (@(posedge clock) disable iff (!reset_n)
        !flush |-> ({2'b00, consume} <= count));

    assign read_req             = read_req_q;
    assign read_addr            = read_addr_q;
    assign prefetch_pc          = pc_q;
    assign prefetch_bus_error   = bus_err_q;
    assign prefetch_addr_error  = addr_err_q;
    assign ir                   = slots[15:0];
    assign prefetch_ir          = {slots[15:0], slots[31:16], slots[47:32]};
    assign prefetch_ir_valid    = count >= PQ_CNT_W'(1);
    assign prefetch_ir_valid_32 = count >= PQ_CNT_W'(2);
    assign prefetch_ir_valid_48 = count >= PQ_CNT_W'(3);

endmodule
